// File: rtl/u_div_pkg.sv
// Shared types and constants for the sequential restoring divider family.
package u_div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width: enough to count the 2N quotient bits down to zero.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/u_seq_restoring_div_if.sv
// Request/response bundle of the sequential divider; the divider is the slave.
interface u_seq_restoring_div_if #(
  parameter int N = u_div_pkg::DIV_N
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/u_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative.
module u_div_step
  import u_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] i_p,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_p,
  output logic         o_q
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;

  // Trial subtraction is N+1 bits wide so the bit shifted out of i_p is kept.
  always_comb begin
    w_shift = {i_p, i_bit};
    w_diff  = w_shift - {1'b0, i_divisor};
    if (w_diff[N] == 1'b0) begin
      o_p = w_diff;
      o_q = 1'b1;
    end else begin
      o_p = w_shift;
      o_q = 1'b0;
    end
  end

endmodule

// File: rtl/u_seq_restoring_div.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, valid/ready on both request and result.
module u_seq_restoring_div
  import u_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input logic                  clk,
  input logic                  rst,
  u_seq_restoring_div_if.slave bus
);

  localparam int CW = cnt_width(N);

  div_state_e     r_state;
  div_state_e     w_next_state;
  logic [N:0]     r_p;
  logic [2*N-1:0] r_q;
  logic [N-1:0]   r_divisor;
  logic [CW-1:0]  r_cnt;
  logic           r_dbz;
  logic [N:0]     w_p_next;
  logic           w_q_bit;
  logic           w_unused_p_msb;

  // P stays below the divisor between steps, so its top bit never feeds back.
  assign w_unused_p_msb = r_p[N];

  u_div_step #(.N(N)) u_step (
    .i_p       (r_p[N-1:0]),
    .i_bit     (r_q[2*N-1]),
    .i_divisor (r_divisor),
    .o_p       (w_p_next),
    .o_q       (w_q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_next_state = (bus.divisor == '0) ? DONE : BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in BUSY, hold results in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_divisor <= bus.divisor;
            r_cnt     <= CW'(2 * N - 1);
            r_p       <= '0;
            if (bus.divisor == '0) begin
              r_q   <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_q   <= bus.dividend;
              r_dbz <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_p <= w_p_next;
          r_q <= {r_q[2*N-2:0], w_q_bit};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_dbz <= 1'b0;
          end
        end
        default: begin
          r_dbz <= 1'b0;
        end
      endcase
    end
  end

  // Output decode; every output comes straight from a register
  always_comb begin
    bus.in_ready    = (r_state == IDLE);
    bus.out_valid   = (r_state == DONE);
    bus.quotient    = r_q;
    bus.remainder   = r_p[N-1:0];
    bus.div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_u_seq_restoring_div.sv
// Self-checking bench for u_seq_restoring_div: directed cases plus randomized
// requests against a plain-arithmetic division model.
module tb_u_seq_restoring_div;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  u_seq_restoring_div_if #(.N(N)) bus ();

  u_seq_restoring_div #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for acceptance, then count edges until out_valid.
  // The accepting edge is counted as edge 1.
  task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv, output int edges);
    int w;
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    w = 0;
    while (!bus.in_ready && w < 64) begin
      step();
      w++;
    end
    check_val("accept_ready", longint'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    edges = 1;
    while (!bus.out_valid && edges < 64) begin
      step();
      edges++;
    end
  endtask

  task automatic check_result(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input int edges);
    longint exp_q;
    longint exp_r;
    longint q;
    longint r;
    if (dv == 8'd0) begin
      exp_q = 65535;
      exp_r = 0;
    end else begin
      exp_q = longint'(dd) / longint'(dv);
      exp_r = longint'(dd) % longint'(dv);
    end
    q = longint'(bus.quotient);
    r = longint'(bus.remainder);
    check_val("latency", longint'(edges), (dv == 8'd0) ? 1 : 17);
    check_val("quotient", q, exp_q);
    check_val("remainder", r, exp_r);
    check_val("div_by_zero", longint'(bus.div_by_zero), (dv == 8'd0) ? 1 : 0);
    if (dv != 8'd0) begin
      check_val("identity", q * longint'(dv) + r, longint'(dd));
      check_val("rem_lt_div", longint'(r < longint'(dv)), 1);
    end
  endtask

  // Complete the result handshake, optionally with random out_ready stalls.
  task automatic handshake(input bit rand_ready);
    int  k;
    bit  rdy;
    k = 0;
    while (k < 40) begin
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.out_ready = rdy;
      step();
      if (rdy) break;
      check_val("stall_valid", longint'(bus.out_valid), 1);
      k++;
    end
    check_val("post_hs_valid", longint'(bus.out_valid), 0);
    check_val("post_hs_ready", longint'(bus.in_ready), 1);
    check_val("post_hs_dbz", longint'(bus.div_by_zero), 0);
  endtask

  task automatic run_req(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input bit rand_ready);
    int edges;
    issue(dd, dv, edges);
    check_result(dd, dv, edges);
    handshake(rand_ready);
  endtask

  initial begin
    int edges;
    int gap;
    logic [2*N-1:0] dd;
    logic [N-1:0]   dv;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check_val("rst_in_ready", longint'(bus.in_ready), 1);
    check_val("rst_out_valid", longint'(bus.out_valid), 0);
    check_val("rst_quotient", longint'(bus.quotient), 0);
    check_val("rst_remainder", longint'(bus.remainder), 0);
    check_val("rst_dbz", longint'(bus.div_by_zero), 0);
    rst = 1'b0;
    step();

    run_req(16'd1000, 8'd7, 1'b0);
    run_req(16'd65535, 8'd255, 1'b0);
    run_req(16'd5, 8'd9, 1'b0);
    run_req(16'd200, 8'd0, 1'b0);

    // Backpressure with an ignored request during the stall
    bus.out_ready = 1'b0;
    issue(16'd1000, 8'd7, edges);
    check_result(16'd1000, 8'd7, edges);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.dividend = 16'd9;
      bus.divisor  = 8'd3;
      step();
      check_val("bp_valid", longint'(bus.out_valid), 1);
      check_val("bp_in_ready", longint'(bus.in_ready), 0);
      check_val("bp_quotient", longint'(bus.quotient), 142);
      check_val("bp_remainder", longint'(bus.remainder), 6);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_val("bp_release_valid", longint'(bus.out_valid), 0);
    check_val("bp_release_ready", longint'(bus.in_ready), 1);

    // Reset during BUSY aborts the division
    bus.in_valid = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    check_val("mid_busy_ready", longint'(bus.in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort_in_ready", longint'(bus.in_ready), 1);
    check_val("abort_out_valid", longint'(bus.out_valid), 0);
    check_val("abort_quotient", longint'(bus.quotient), 0);
    run_req(16'd48, 8'd5, 1'b0);

    // Randomized requests with idle gaps and result stalls
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      dd = 16'($urandom);
      dv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (i % 8 == 0) dv = 8'($urandom_range(1, 3));
      bus.out_ready = 1'($urandom_range(0, 1));
      run_req(dd, dv, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/u_seq_restoring_div.md
Name: u_seq_restoring_div

Overview:
- Sequential unsigned restoring divider, the inverse operation of the unsigned array/BAM multipliers in the generated-circuits library.
- Takes a 2N-bit dividend (a multiplier product width) and an N-bit divisor.
- Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Used as the exact reference/recovery path when evaluating approximate multiplier outputs in hardware test harnesses.

Parameters:
- N, 8, divisor and remainder width; dividend and quotient are 2N bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- quotient  output  2N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0. The state machine returns to IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge where in_valid=1.
  - On accept, latch the divisor. Load the partial remainder register P (N+1 bits) with 0 and the quotient/dividend shift register Q with dividend. Load the iteration counter with 2N-1.
  - If divisor==0: go to DONE with quotient = all ones, remainder = 0, div_by_zero=1. No iterations are run.
  - Otherwise go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: T = {P[N-1:0], Q[2N-1]} - {1'b0, divisor}.
  - If T is non-negative (MSB 0): P <= T and shift 1 into Q's LSB. Otherwise P <= {P[N-1:0], Q[2N-1]} and shift 0 into Q's LSB.
  - When the counter reaches 0 after this step, go to DONE. Otherwise decrement the counter.
- DONE:
  - out_valid=1; quotient=Q, remainder=P[N-1:0], in_ready=0.
  - Outputs stay stable until out_ready=1. On that edge, go to IDLE and clear out_valid.
  - out_ready held high is allowed: DONE lasts exactly one cycle.
- Latency:
  - Nonzero divisor: out_valid rises 2N+1 edges after the accepting edge (17 for N=8).
  - Zero divisor: out_valid rises 1 edge after the accepting edge.
- Throughput: no pipelining. A new request is accepted only in IDLE, so the earliest re-accept is the cycle after the result handshake.
- in_valid while busy is ignored and nothing is captured. Input values only matter on the accepting edge.
- Reset mid-operation (BUSY or DONE) aborts the operation with no output handshake. All outputs take their reset values on the next edge.
- Width rules:
  - The subtraction is N+1 bits wide, so the carry out of the shifted partial remainder is never lost.
  - remainder < divisor is always true for a nonzero divisor.
  - quotient*divisor + remainder == dividend exactly.
- div_by_zero is only meaningful while out_valid=1. It clears when the block leaves DONE.

Decomposition:
- Shared package u_div_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - default width constant N=8.
  - counter width function $clog2(2N).
- One natural sub-module: u_div_step, a combinational single restoring step.
  - Inputs: P, next dividend bit, divisor.
  - Outputs: next P, quotient bit.
  - It is reused by the iterative core and by the team's future unrolled divider.

Test Plan:
- dividend=1000, divisor=7, out_ready=1 -> out_valid exactly 17 edges after accept; quotient=142, remainder=6, div_by_zero=0.
- dividend=65535, divisor=255 -> quotient=257, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=200, divisor=0 -> out_valid 1 edge after accept; quotient=65535, remainder=0, div_by_zero=1.
- Backpressure: 1000/7 with out_ready=0 for 5 cycles -> outputs held stable and in_ready=0 throughout. Pulse in_valid with 9/3 during the stall -> ignored. After out_ready, in_ready=1 on the next cycle.
- Reset asserted for one cycle at BUSY iteration 6 -> next edge: in_ready=1, out_valid=0. The new request 48/5 then yields quotient=9, remainder=3.
- Randomized 1000 requests vs reference model, random in_valid/out_ready gaps -> quotient*divisor+remainder==dividend and remainder<divisor for every result.
